riscv_mc_controller: RTL and testbench
======================================

# riscv_mc_controller

Multi-cycle control FSM for the RV32I multi-cycle datapath. Each cycle it drives every datapath control input from the decoded `op`, `func3` and `func7` and from the ALU `zero` flag. It sequences fetch, decode, execute, memory and write-back, one instruction at a time. It sits beside the datapath at top level; its outputs connect 1:1 to the datapath's control inputs of the same name.

## Interface
- No parameters.
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- op  in  7  instruction[6:0] from instruction register
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- zero  in  1  ALU zero flag (combinational, current cycle)
- PCSrc, branch, jalr, MemWrite, RegWrite, AdrSrc, IrWrite  out  1 each  datapath strobes/selects
- ResultSrc, ALUSrcA, ALUSrcB  out  2 each  mux selects
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU
- illegal  out  1  one-cycle pulse in DECODE on an unsupported op
- instr_done  out  1  one-cycle pulse in an instruction's last state
- state  out  4  current state, for verification only

## Operation
- Encodings:
  - ALUSrcA: 00 PC, 01 oldPC, 10 A.
  - ALUSrcB: 00 B, 01 imm, 10 const 4.
  - ResultSrc: 00 ALUOut, 01 DataMem, 10 ALUresult, 11 imm.
  - AdrSrc: 0 PC, 1 Result.
- Outputs are Moore, decoded from state; the only exceptions are ImmSrc/ALUControl selection and branch PCSrc (functions of op/func3/func7/zero). Every signal not listed for a state is 0.
- FETCH: AdrSrc=0, IrWrite=1, SrcA=PC, SrcB=4, ADD, ResultSrc=10, PCSrc=1 -> DECODE.
- DECODE: SrcA=oldPC, SrcB=imm, ADD (target into ALUOut); ImmSrc=J if op=1101111, else B. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - anything else -> FETCH with illegal=1
- MEMADR: SrcA=A, SrcB=imm, ADD, ImmSrc=I (load) or S (store) -> MEMREAD (load) / MEMWRITE (store).
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done -> FETCH.
- EXEC_R: SrcA=A, SrcB=B -> ALUWB. ALUControl by func3:
  - 000: SUB if func7[5]=1, else ADD
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU
  - other: ADD
- EXEC_I: SrcA=A, SrcB=imm, ImmSrc=I, same func3 map; func3 000 is always ADD -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done -> FETCH.
- BRANCH: SrcA=A, SrcB=B, ResultSrc=00, instr_done -> FETCH.
  - ALUControl: SUB for func3 000/001, SLT for 100/101, SLTU for 110/111.
  - branch = (func3==000).
  - PCSrc = 1 iff (001 and !zero) or (100/110 and !zero) or (101/111 and zero).
  - Net effect: PC loads target iff branch taken; beq is taken via the datapath's branch&zero path.
- JAL: SrcA=oldPC, SrcB=4, ADD, ResultSrc=00, PCSrc=1 (PC <= target; ALUOut <= oldPC+4) -> ALUWB.
- JALR: SrcA=A, SrcB=imm, ImmSrc=I, ADD, ResultSrc=10, PCSrc=1, jalr=1 -> JALR_WB.
- JALR_WB: SrcA=oldPC, SrcB=4, ADD, ResultSrc=10, RegWrite=1, instr_done -> FETCH.
  - PC is updated before rd is written, so the rd==rs1 case is safe.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite=1, instr_done -> FETCH.

## Timing
- Reset: while RST=1 at a rising edge, state <= FETCH. While RST is high, every output is forced to 0, including state=0000 (FETCH).
- The first FETCH strobes appear in the first cycle after RST falls.
- Reset asserted mid-instruction aborts it at the next edge: no further RegWrite/MemWrite.
- Cycles per instruction, including FETCH:
  - lw 5; sw 4; R 4; I 4
  - branch 3; jal 4; jalr 4; lui 3
  - illegal 2
- zero is sampled combinationally in BRANCH only. X on zero in other states must not propagate to any output.
- State encoding (4 bits):
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6
  - EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALR_WB 12, LUI 13
  - Unused codes 14/15 -> FETCH next cycle, all outputs 0.

## Test plan
- Reset, then op=0000011: states 0,1,2,3,4,0. RegWrite only in state 4 with ResultSrc=01; one instr_done pulse.
- op=0110011, func3=000, func7=0100000: EXEC_R shows ALUControl=0001. ALUWB shows RegWrite=1, ResultSrc=00.
- op=1100011, func3=001: zero=0 gives PCSrc=1, branch=0; zero=1 gives PCSrc=0. func3=000 with zero=1 gives branch=1, PCSrc=0.
- op=1100111: JALR has PCSrc=1, jalr=1, ResultSrc=10. JALR_WB has RegWrite=1, SrcA=01, SrcB=10.
- op=1111111: illegal=1 in DECODE, next state FETCH, no RegWrite/MemWrite asserted.
- RST raised during MEMWRITE (op=0100011): MemWrite=0 that cycle, state=0 after the edge.

Source files
------------

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath control input from the current state and instruction.
module riscv_mc_controller (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       PCSrc,
  output logic       branch,
  output logic       jalr,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       IrWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALR_WB  = 4'd12,
    LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;

  localparam logic [1:0] SA_PC  = 2'b00;
  localparam logic [1:0] SA_OLD = 2'b01;
  localparam logic [1:0] SA_A   = 2'b10;
  localparam logic [1:0] SB_B   = 2'b00;
  localparam logic [1:0] SB_IMM = 2'b01;
  localparam logic [1:0] SB_4   = 2'b10;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MEM    = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;
  localparam logic [1:0] RS_IMM    = 2'b11;

  state_t cur;
  state_t nxt;

  logic unused_f7;
  assign unused_f7 = ^{func7[6], func7[4:0]};

  function automatic logic [3:0] alu_map(
    input logic [2:0] f3,
    input logic       sub
  );
    case (f3)
      3'b000:  alu_map = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_map = ALU_AND;
      3'b110:  alu_map = ALU_OR;
      3'b100:  alu_map = ALU_XOR;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      default: alu_map = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt        = FETCH;
    PCSrc      = 1'b0;
    branch     = 1'b0;
    jalr       = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IrWrite    = 1'b0;
    ResultSrc  = RS_ALUOUT;
    ALUSrcA    = SA_PC;
    ALUSrcB    = SB_B;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;
    state      = 4'd0;
    if (!RST) begin
      state = cur;
      case (cur)
        FETCH: begin
          IrWrite   = 1'b1;
          ALUSrcB   = SB_4;
          ResultSrc = RS_ALU;
          PCSrc     = 1'b1;
          nxt       = DECODE;
        end
        DECODE: begin
          ALUSrcA = SA_OLD;
          ALUSrcB = SB_IMM;
          ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
          unique case (1'b1)
            (op == OP_LOAD || op == OP_STORE): nxt = MEMADR;
            (op == OP_R):    nxt = EXEC_R;
            (op == OP_I):    nxt = EXEC_I;
            (op == OP_BR):   nxt = BRANCH;
            (op == OP_JAL):  nxt = JAL;
            (op == OP_JALR): nxt = JALR;
            (op == OP_LUI):  nxt = LUI;
            default:         illegal = 1'b1;
          endcase
        end
        MEMADR: begin
          ALUSrcA = SA_A;
          ALUSrcB = SB_IMM;
          ImmSrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
          nxt     = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          AdrSrc = 1'b1;
          nxt    = MEMWB;
        end
        MEMWB: begin
          ResultSrc  = RS_MEM;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_R: begin
          ALUSrcA    = SA_A;
          ALUControl = alu_map(func3, func7[5]);
          nxt        = ALUWB;
        end
        EXEC_I: begin
          ALUSrcA    = SA_A;
          ALUSrcB    = SB_IMM;
          ALUControl = alu_map(func3, 1'b0);
          nxt        = ALUWB;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = SA_A;
          instr_done = 1'b1;
          branch     = (func3 == 3'b000);
          case (func3)
            3'b000, 3'b001: ALUControl = ALU_SUB;
            3'b100, 3'b101: ALUControl = ALU_SLT;
            3'b110, 3'b111: ALUControl = ALU_SLTU;
            default:        ALUControl = ALU_ADD;
          endcase
          // beq resolves through branch&zero in the datapath, not PCSrc
          case (func3)
            3'b001, 3'b100, 3'b110: PCSrc = ~zero;
            3'b101, 3'b111:         PCSrc = zero;
            default:                PCSrc = 1'b0;
          endcase
        end
        JAL: begin
          ALUSrcA = SA_OLD;
          ALUSrcB = SB_4;
          PCSrc   = 1'b1;
          nxt     = ALUWB;
        end
        JALR: begin
          ALUSrcA   = SA_A;
          ALUSrcB   = SB_IMM;
          ResultSrc = RS_ALU;
          PCSrc     = 1'b1;
          jalr      = 1'b1;
          nxt       = JALR_WB;
        end
        JALR_WB: begin
          ALUSrcA    = SA_OLD;
          ALUSrcB    = SB_4;
          ResultSrc  = RS_ALU;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        LUI: begin
          ImmSrc     = IMM_U;
          ResultSrc  = RS_IMM;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Randomized instruction streams checked every cycle against a
// per-instruction state-sequence and output-table model.
module tb_riscv_mc_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       PCSrc, branch, jalr, MemWrite, RegWrite, AdrSrc, IrWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal, instr_done;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  logic [25:0] dv;
  logic [25:0] obs [0:7];

  always #5 CLK = ~CLK;

  riscv_mc_controller dut (
    .CLK(CLK), .RST(RST), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .PCSrc(PCSrc), .branch(branch), .jalr(jalr),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .IrWrite(IrWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  assign dv = {PCSrc, branch, jalr, MemWrite, RegWrite, AdrSrc, IrWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               illegal, instr_done, state};

  task automatic chk(input string nm, input logic [25:0] got,
                     input logic [25:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (op=%b f3=%b)",
               nm, got, want, op, func3);
    end
  endtask

  // State walk of one instruction, including FETCH.
  function automatic int seq(input logic [6:0] o, output int s [0:4]);
    s = '{0, 1, 0, 0, 0};
    case (o)
      7'b0000011: begin s[2] = 2;  s[3] = 3; s[4] = 4; return 5; end
      7'b0100011: begin s[2] = 2;  s[3] = 5; return 4; end
      7'b0110011: begin s[2] = 6;  s[3] = 8; return 4; end
      7'b0010011: begin s[2] = 7;  s[3] = 8; return 4; end
      7'b1100011: begin s[2] = 9;  return 3; end
      7'b1101111: begin s[2] = 10; s[3] = 8; return 4; end
      7'b1100111: begin s[2] = 11; s[3] = 12; return 4; end
      7'b0110111: begin s[2] = 13; return 3; end
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] fmap(input logic [2:0] f3, input logic sub);
    if (f3 == 3'd0) return sub ? 4'd1 : 4'd0;
    if (f3 == 3'd7) return 4'd2;
    if (f3 == 3'd6) return 4'd3;
    if (f3 == 3'd4) return 4'd4;
    if (f3 == 3'd2) return 4'd5;
    if (f3 == 3'd3) return 4'd6;
    return 4'd0;
  endfunction

  function automatic logic [25:0] exp_out(input int s, input logic [6:0] o,
    input logic [2:0] f3, input logic [6:0] f7, input logic z);
    logic pc, br, jr, mw, rw, ad, ir, il, dn;
    logic [1:0] rs, sa, sb;
    logic [2:0] im;
    logic [3:0] al, st;
    bit legal;
    {pc, br, jr, mw, rw, ad, ir, il, dn} = '0;
    rs = 0; sa = 0; sb = 0; im = 0; al = 0;
    st = s[3:0];
    legal = (o == 7'h03) || (o == 7'h23) || (o == 7'h33) || (o == 7'h13) ||
            (o == 7'h63) || (o == 7'h6f) || (o == 7'h67) || (o == 7'h37);
    case (s)
      0:  begin ir = 1; sb = 2; rs = 2; pc = 1; end
      1:  begin sa = 1; sb = 1; im = (o == 7'h6f) ? 3'd4 : 3'd2; il = !legal; end
      2:  begin sa = 2; sb = 1; im = (o == 7'h03) ? 3'd0 : 3'd1; end
      3:  ad = 1;
      4:  begin rs = 1; rw = 1; dn = 1; end
      5:  begin ad = 1; mw = 1; dn = 1; end
      6:  begin sa = 2; al = fmap(f3, f7[5]); end
      7:  begin sa = 2; sb = 1; al = fmap(f3, 1'b0); end
      8:  begin rw = 1; dn = 1; end
      9:  begin
        sa = 2; dn = 1; br = (f3 == 0);
        al = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd5 : 4'd6;
        pc = ((f3 == 1 || f3 == 4 || f3 == 6) && !z) ||
             ((f3 == 5 || f3 == 7) && z);
      end
      10: begin sa = 1; sb = 2; pc = 1; end
      11: begin sa = 2; sb = 1; rs = 2; pc = 1; jr = 1; end
      12: begin sa = 1; sb = 2; rs = 2; rw = 1; dn = 1; end
      13: begin im = 3; rs = 3; rw = 1; dn = 1; end
      default: ;
    endcase
    return {pc, br, jr, mw, rw, ad, ir, rs, sa, sb, im, al, il, dn, st};
  endfunction

  // Called #1 after a rising edge; leaves #1 after the next one.
  task automatic rst_cycle();
    RST = 1'b1;
    op = 7'($urandom);
    func3 = 3'($urandom);
    func7 = 7'($urandom);
    zero = 1'($urandom);
    @(negedge CLK);
    chk("reset", dv, 26'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
    input logic [6:0] f7, input int zfix, input int abort_at);
    int s [0:4];
    int n;
    logic z;
    n = seq(o, s);
    for (int i = 0; i < 8; i++) obs[i] = '0;
    op = o; func3 = f3; func7 = f7;
    for (int i = 0; i < n; i++) begin
      RST = (i == abort_at);
      if (s[i] == 9) begin
        z = (zfix >= 0) ? 1'(zfix) : 1'($urandom);
        zero = z;
      end else begin
        z = 1'b0;
        zero = 1'bx;
      end
      @(negedge CLK);
      obs[i] = dv;
      chk("step", dv, RST ? 26'd0 : exp_out(s[i], o, f3, f7, zero));
      @(posedge CLK);
      #1;
      if (RST) begin
        RST = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int rw_cnt, dn_cnt;
    logic [6:0] ops [0:7];
    logic [6:0] o;
    logic [2:0] f3;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37};
    RST = 1'b1; op = 0; func3 = 0; func7 = 0; zero = 0;
    @(posedge CLK);
    #1;
    rst_cycle();
    rst_cycle();
    RST = 1'b0;

    run_instr(7'b0000011, 3'b010, 7'd0, -1, -1);
    chk("lw_s0", 26'(obs[0][3:0]), 26'd0);
    chk("lw_s1", 26'(obs[1][3:0]), 26'd1);
    chk("lw_s2", 26'(obs[2][3:0]), 26'd2);
    chk("lw_s3", 26'(obs[3][3:0]), 26'd3);
    chk("lw_s4", 26'(obs[4][3:0]), 26'd4);
    chk("lw_res", 26'(obs[4][18:17]), 26'd1);
    rw_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rw_cnt += int'(obs[i][21]);
      dn_cnt += int'(obs[i][4]);
    end
    chk("lw_rw_once", 26'(rw_cnt), 26'd1);
    chk("lw_rw_s4", 26'(obs[4][21]), 26'd1);
    chk("lw_done", 26'(dn_cnt), 26'd1);

    run_instr(7'b0110011, 3'b000, 7'b0100000, -1, -1);
    chk("sub_alu", 26'(obs[2][9:6]), 26'd1);
    chk("sub_wb", 26'({obs[3][21], obs[3][18:17]}), 26'b100);

    run_instr(7'b1100011, 3'b001, 7'd0, 0, -1);
    chk("bne_z0", 26'(obs[2][25:24]), 26'b10);
    run_instr(7'b1100011, 3'b001, 7'd0, 1, -1);
    chk("bne_z1", 26'(obs[2][25]), 26'd0);
    run_instr(7'b1100011, 3'b000, 7'd0, 1, -1);
    chk("beq_z1", 26'(obs[2][25:24]), 26'b01);

    run_instr(7'b1100111, 3'b000, 7'd0, -1, -1);
    chk("jalr", 26'({obs[2][25], obs[2][23], obs[2][18:17]}), 26'b1110);
    chk("jalr_wb", 26'({obs[3][21], obs[3][16:13]}), 26'b10110);

    run_instr(7'b1111111, 3'b000, 7'd0, -1, -1);
    chk("ill", 26'(obs[1][5]), 26'd1);
    chk("ill_nowr", 26'({obs[0][22:21], obs[1][22:21]}), 26'd0);

    run_instr(7'b0100011, 3'b010, 7'd0, -1, 3);
    chk("sw_rst_mw", 26'(obs[3][22]), 26'd0);
    run_instr(7'b0110111, 3'b000, 7'd0, -1, -1);
    chk("after_rst", 26'(obs[0][3:0]), 26'd0);

    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = $urandom_range(0, 8);
      o = (sel == 8) ? 7'($urandom) : ops[sel];
      f3 = 3'($urandom);
      if (o == 7'h63) while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom);
      run_instr(o, f3, 7'($urandom), -1,
                ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
